// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//
// Bridges the 64-bit LEGv8 data port onto a 32-bit wait-stated memory bus.
// Each 64-bit access becomes up to two 32-bit beats: LO at addr+0 and HI at
// addr+4. A beat is skipped when its half of the byte enables is all zero.
// oStall holds the CPU until the access reaches DONE.
//
// Ports
//   iCLK, iRST        clock, synchronous active-high reset
//   iReadEnable       CPU load request
//   iWriteEnable      CPU store request (wins if both are high)
//   iAddress[63:0]    byte address, only [31:0] used, must be 8-byte aligned
//   iWriteData[63:0]  store data
//   iByteEnable[7:0]  byte lanes, bit n covers byte n
//   oReadData[63:0]   assembled load data, updated when a read reaches DONE
//   oStall            CPU must not advance while high
//   oMisaligned       one-cycle pulse, request rejected for misalignment
//   oTimeout          one-cycle pulse, a beat was aborted
//   oM*               registered 32-bit bus beat (address/data/BE/strobes)
//   iMReadData        beat read data
//   iMWaitRequest     slave not ready, beat is held
//   oDbgState         current FSM state (IDLE=0, LO=1, HI=2, DONE=3)
//
// Handshake: a beat is presented with oMRead or oMWrite high and all oM*
// fields stable; it completes in the first cycle where the strobe is high
// and iMWaitRequest is low, or is aborted once the wait counter has reached
// TIMEOUT_CYCLES and iMWaitRequest is still high.
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [63:0] iAddress,
    input  logic [63:0] iWriteData,
    input  logic [7:0]  iByteEnable,
    output logic [63:0] oReadData,
    output logic        oStall,
    output logic        oMisaligned,
    output logic        oTimeout,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    output logic [3:0]  oMByteEnable,
    output logic        oMRead,
    output logic        oMWrite,
    input  logic [31:0] iMReadData,
    input  logic        iMWaitRequest,
    output logic [1:0]  oDbgState
);

    // Counter is wide enough to hold TIMEOUT_CYCLES itself.
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, nextState;

    logic [31:0]   addrQ;
    logic [63:0]   wdataQ;
    logic [7:0]    beQ;
    logic          writeQ;
    logic [31:0]   loQ;
    logic [CW-1:0] waitCnt;

    logic        req, aligned, accept, inBeat, abort, beatDone;
    logic [31:0] beatData;
    logic [63:0] assembled;

    logic [31:0] srcAddr;
    logic [63:0] srcData;
    logic [7:0]  srcBe;
    logic        srcWrite;
    logic [31:0] mAddrNext, mDataNext;
    logic [3:0]  mBeNext;
    logic        mReadNext, mWriteNext;

    // Upper address bits are architecturally ignored.
    logic unusedAddrHi;
    assign unusedAddrHi = ^iAddress[63:32];

    // Request decode and beat completion
    always_comb begin
        req      = iReadEnable | iWriteEnable;
        aligned  = (iAddress[2:0] == 3'b000);
        accept   = (state == IDLE) && req && aligned && (iByteEnable != 8'h00);
        inBeat   = (state == LO) || (state == HI);
        abort    = inBeat && iMWaitRequest && (waitCnt == WAIT_MAX);
        beatDone = inBeat && (!iMWaitRequest || abort);
        beatData = abort ? ERR_DATA : iMReadData;
        // Combinational in IDLE so the request cycle itself is stalled.
        oStall   = accept || inBeat;
        oDbgState = state;
        // Only meaningful on the beat that enters DONE; a skipped LO leaves
        // loQ at the zero loaded on accept, a skipped HI contributes zero here.
        assembled = {(state == HI) ? beatData : 32'h0,
                     (state == LO) ? beatData : loQ};
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (accept) nextState = (iByteEnable[3:0] != 4'h0) ? LO : HI;
            LO:   if (beatDone) nextState = (beQ[7:4] != 4'h0) ? HI : DONE;
            HI:   if (beatDone) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Bus fields for the state being entered. From IDLE the request has not
    // been latched yet, so take it straight from the inputs.
    always_comb begin
        srcAddr    = (state == IDLE) ? iAddress[31:0] : addrQ;
        srcData    = (state == IDLE) ? iWriteData     : wdataQ;
        srcBe      = (state == IDLE) ? iByteEnable    : beQ;
        srcWrite   = (state == IDLE) ? iWriteEnable   : writeQ;
        mAddrNext  = 32'h0;
        mDataNext  = 32'h0;
        mBeNext    = 4'h0;
        mReadNext  = 1'b0;
        mWriteNext = 1'b0;
        unique case (nextState)
            LO: begin
                mAddrNext  = {srcAddr[31:3], 3'b000};
                mDataNext  = srcData[31:0];
                mBeNext    = srcBe[3:0];
                mReadNext  = !srcWrite;
                mWriteNext = srcWrite;
            end
            HI: begin
                mAddrNext  = {srcAddr[31:3], 3'b100};
                mDataNext  = srcData[63:32];
                mBeNext    = srcBe[7:4];
                mReadNext  = !srcWrite;
                mWriteNext = srcWrite;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            oReadData    <= 64'h0;
            oMAddress    <= 32'h0;
            oMWriteData  <= 32'h0;
            oMByteEnable <= 4'h0;
            oMRead       <= 1'b0;
            oMWrite      <= 1'b0;
            oMisaligned  <= 1'b0;
            oTimeout     <= 1'b0;
            waitCnt      <= '0;
            addrQ        <= 32'h0;
            wdataQ       <= 64'h0;
            beQ          <= 8'h0;
            writeQ       <= 1'b0;
            loQ          <= 32'h0;
        end else begin
            state        <= nextState;
            oMAddress    <= mAddrNext;
            oMWriteData  <= mDataNext;
            oMByteEnable <= mBeNext;
            oMRead       <= mReadNext;
            oMWrite      <= mWriteNext;
            oMisaligned  <= (state == IDLE) && req && !aligned;
            oTimeout     <= abort;

            if (accept) begin
                addrQ  <= iAddress[31:0];
                wdataQ <= iWriteData;
                beQ    <= iByteEnable;
                writeQ <= iWriteEnable;
                loQ    <= 32'h0;
            end
            if ((state == LO) && beatDone) loQ <= beatData;

            if (inBeat && (nextState == DONE) && !writeQ) oReadData <= assembled;

            // Fresh count on every beat entry; counts wait cycles within a beat.
            if (nextState != state)
                waitCnt <= '0;
            else if (inBeat && iMWaitRequest)
                waitCnt <= waitCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
module tb_dmem_bus_bridge;
  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int          W   = 70;

  // clock / reset
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  logic        iReadEnable = 1'b0, iWriteEnable = 1'b0;
  logic [63:0] iAddress = 64'h0, iWriteData = 64'h0;
  logic [7:0]  iByteEnable = 8'h0;
  logic [63:0] oReadData;
  logic        oStall, oMisaligned, oTimeout;
  logic [31:0] oMAddress, oMWriteData;
  logic [3:0]  oMByteEnable;
  logic        oMRead, oMWrite;
  logic [31:0] iMReadData = 32'h0;
  logic        iMWaitRequest = 1'b0;
  logic [1:0]  oDbgState;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERR)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iReadEnable(iReadEnable), .iWriteEnable(iWriteEnable),
    .iAddress(iAddress), .iWriteData(iWriteData), .iByteEnable(iByteEnable),
    .oReadData(oReadData), .oStall(oStall),
    .oMisaligned(oMisaligned), .oTimeout(oTimeout),
    .oMAddress(oMAddress), .oMWriteData(oMWriteData), .oMByteEnable(oMByteEnable),
    .oMRead(oMRead), .oMWrite(oMWrite),
    .iMReadData(iMReadData), .iMWaitRequest(iMWaitRequest),
    .oDbgState(oDbgState)
  );

  // scoreboard: expected beats {rd, wr, addr, be, data}
  logic [W-1:0] exp_q[$];
  logic [31:0]  mem [logic [31:0]];
  logic [63:0]  lastRd;
  int nVec = 0;
  int nFail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memRd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic memWr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] v;
    v = memRd(a);
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
    mem[a] = v;
  endtask

  // Reference model: beats, stall length, pulses and load result from the
  // access rules alone.
  task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [7:0] be,
                       input int wLo, input int wHi,
                       output int eStall, output int eTo, output int eMis,
                       output logic [63:0] eRd);
    logic [63:0] v;
    logic [31:0] ba;
    int w;
    bit ab;
    v = 64'h0;
    eStall = 0; eTo = 0; eMis = 0;
    if (rd | wr) begin
      if (addr[2:0] != 3'b000) eMis = 1;
      else if (be != 8'h00) begin
        eStall = 1;
        for (int h = 0; h < 2; h++) begin
          if (be[4*h +: 4] != 4'h0) begin
            w  = (h == 1) ? wHi : wLo;
            ab = (w > T);
            eStall += ab ? T + 1 : w + 1;
            if (ab) eTo++;
            ba = {addr[31:3], 3'b000} + 32'(4 * h);
            exp_q.push_back({!wr, wr, ba, be[4*h +: 4], wdata[32*h +: 32]});
            v[32*h +: 32] = ab ? ERR : memRd(ba);
          end
        end
        if (!wr) lastRd = v;
      end
    end
    eRd = lastRd;
  endtask

  // Driver + slave: holds the CPU request until the stall drops, acts as a
  // wait-stated memory, checks each beat against the scoreboard.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [7:0] be,
                           input int wLo, input int wHi,
                           output int stallN, output int toN, output int misN,
                           output logic [63:0] rdEnd);
    int beatCyc, cyc, w;
    bit done;
    logic [W-1:0] cur, obs;
    beatCyc = 0; cyc = 0; done = 0; cur = '0;
    stallN = 0; toN = 0; misN = 0; rdEnd = 64'h0;
    while (!done) begin
      @(negedge iCLK);
      iReadEnable  = rd;
      iWriteEnable = wr;
      iAddress     = {$urandom, addr};
      iWriteData   = wdata;
      iByteEnable  = be;
      if (oMRead | oMWrite) begin
        w = oMAddress[2] ? wHi : wLo;
        iMWaitRequest = (beatCyc < w);
        iMReadData    = iMWaitRequest ? $urandom : memRd(oMAddress);
      end else begin
        iMWaitRequest = 1'($urandom_range(0, 1));
        iMReadData    = $urandom;
      end
      #1;
      if (oStall) stallN++;
      if (oTimeout) toN++;
      if (oMisaligned) misN++;
      if (oMRead | oMWrite) begin
        obs = {oMRead, oMWrite, oMAddress, oMByteEnable, oMWriteData};
        if (beatCyc == 0) begin
          if (exp_q.size() == 0) begin
            nVec++; nFail++;
            $display("FAIL unexpected_beat: got %h expected none", obs);
          end else chk("beat", obs, exp_q.pop_front());
          cur = obs;
        end else chk("beat_hold", obs, cur);
        if (!iMWaitRequest) begin
          if (oMWrite) memWr(oMAddress, oMWriteData, oMByteEnable);
          beatCyc = 0;
        end else if (beatCyc == T) beatCyc = 0;
        else beatCyc++;
      end
      if (!oStall) begin
        done  = 1;
        rdEnd = oReadData;
      end
      cyc++;
      if (!done && cyc > 100) begin
        chk("access_bound", W'(cyc), W'(0));
        done = 1;
      end
    end
    // CPU has moved on: drop the request and collect trailing pulses.
    @(negedge iCLK);
    iReadEnable = 1'b0; iWriteEnable = 1'b0; iMWaitRequest = 1'b0;
    #1;
    if (oTimeout) toN++;
    if (oMisaligned) misN++;
    chk("strobes_after", W'({oMRead, oMWrite}), W'(0));
    chk("state_after", W'(oDbgState), W'(0));
    chk("beats_left", W'(exp_q.size()), W'(0));
    exp_q.delete();
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          wLo, wHi;
    int          expStall, expTo, expMis;
    logic [63:0] expRd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int sN, tN, mN, eS, eT, eM;
    logic [63:0] rN, eR;
    logic rd, wr;
    logic [31:0] a;
    logic [7:0] be;
    int wl, wh, kind;

    //             rd    wr    addr          wdata                  be     wLo wHi stall to mis rd
    tbl[0] = '{1'b1, 1'b0, 32'h100, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0,  3, 0, 0, 64'h2222_2222_1111_1111};
    tbl[1] = '{1'b0, 1'b1, 32'h208, 64'hAABB_CCDD_EEFF_0011, 8'hF0, 0, 0,  2, 0, 0, 64'h2222_2222_1111_1111};
    tbl[2] = '{1'b1, 1'b0, 32'h300, 64'h0,                   8'hFF, 3, 0,  6, 0, 0, 64'h4444_4444_3333_3333};
    tbl[3] = '{1'b1, 1'b0, 32'h400, 64'h0,                   8'hFF, 9, 9, 11, 2, 0, 64'hDEAD_BEEF_DEAD_BEEF};
    tbl[4] = '{1'b1, 1'b0, 32'h103, 64'h0,                   8'hFF, 0, 0,  0, 0, 1, 64'hDEAD_BEEF_DEAD_BEEF};
    tbl[5] = '{1'b1, 1'b0, 32'h208, 64'h0,                   8'hF0, 1, 2,  4, 0, 0, 64'hAABB_CCDD_0000_0000};
    tbl[6] = '{1'b1, 1'b0, 32'h500, 64'h0,                   8'h00, 0, 0,  0, 0, 0, 64'hAABB_CCDD_0000_0000};
    tbl[7] = '{1'b1, 1'b1, 32'h600, 64'h9999_9999_1234_5678, 8'h0F, 0, 0,  2, 0, 0, 64'hAABB_CCDD_0000_0000};
    tbl[8] = '{1'b1, 1'b0, 32'h600, 64'h0,                   8'h03, 0, 0,  2, 0, 0, 64'h0000_0000_1234_5678};

    mem[32'h100] = 32'h1111_1111;
    mem[32'h104] = 32'h2222_2222;
    mem[32'h300] = 32'h3333_3333;
    mem[32'h304] = 32'h4444_4444;
    mem[32'h600] = 32'h0;
    lastRd = 64'h0;

    // reset state
    repeat (3) @(negedge iCLK);
    #1;
    chk("rst_state", W'(oDbgState), W'(0));
    chk("rst_rdata", W'(oReadData), W'(0));
    chk("rst_bus", W'({oMRead, oMWrite, oMAddress, oMByteEnable, oMWriteData}), W'(0));
    chk("rst_pulses", W'({oStall, oMisaligned, oTimeout}), W'(0));
    @(negedge iCLK);
    iRST = 1'b0;

    // directed table
    for (int i = 0; i < 9; i++) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be,
            tbl[i].wLo, tbl[i].wHi, eS, eT, eM, eR);
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                tbl[i].wLo, tbl[i].wHi, sN, tN, mN, rN);
      chk($sformatf("tbl%0d_stall", i), W'(sN), W'(tbl[i].expStall));
      chk($sformatf("tbl%0d_timeout", i), W'(tN), W'(tbl[i].expTo));
      chk($sformatf("tbl%0d_misaligned", i), W'(mN), W'(tbl[i].expMis));
      chk($sformatf("tbl%0d_rdata", i), W'(rN), W'(tbl[i].expRd));
    end

    // reset in the middle of the HI beat
    @(negedge iCLK);
    iReadEnable = 1'b1; iAddress = 64'h100; iByteEnable = 8'hFF; iMWaitRequest = 1'b0;
    #1 chk("mid_rst_c0_stall", W'(oStall), W'(1));
    @(negedge iCLK);
    iMReadData = memRd(oMAddress);
    #1 chk("mid_rst_lo", W'({oMRead, oMAddress}), W'({1'b1, 32'h100}));
    @(negedge iCLK);
    iMReadData = memRd(oMAddress);
    #1 chk("mid_rst_hi", W'({oMRead, oMAddress}), W'({1'b1, 32'h104}));
    iRST = 1'b1;
    @(negedge iCLK);
    iReadEnable = 1'b0;
    #1;
    chk("mid_rst_state", W'(oDbgState), W'(0));
    chk("mid_rst_mread", W'(oMRead), W'(0));
    chk("mid_rst_rdata", W'(oReadData), W'(0));
    iRST = 1'b0;
    lastRd = 64'h0;
    model(1'b1, 1'b0, 32'h100, 64'h0, 8'hFF, 0, 0, eS, eT, eM, eR);
    do_access(1'b1, 1'b0, 32'h100, 64'h0, 8'hFF, 0, 0, sN, tN, mN, rN);
    chk("post_rst_stall", W'(sN), W'(3));
    chk("post_rst_rdata", W'(rN), W'(64'h2222_2222_1111_1111));

    // randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      a  = {20'h0, 9'($urandom_range(0, 511)), 3'b000};
      if ($urandom_range(0, 7) == 0) a[2:0] = 3'($urandom_range(1, 7));
      be = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      wl = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 3);
      wh = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 3);
      model(rd, wr, a, {$urandom, $urandom}, be, wl, wh, eS, eT, eM, eR);
      do_access(rd, wr, a, exp_q.size() > 0 ? {exp_q[exp_q.size()-1][31:0], exp_q[0][31:0]} : 64'h0,
                be, wl, wh, sN, tN, mN, rN);
      chk($sformatf("rnd%0d_stall", i), W'(sN), W'(eS));
      chk($sformatf("rnd%0d_timeout", i), W'(tN), W'(eT));
      chk($sformatf("rnd%0d_misaligned", i), W'(mN), W'(eM));
      chk($sformatf("rnd%0d_rdata", i), W'(rN), W'(eR));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
